// File: rtl/fm_demod.sv
// fm_demod -- FM discriminator for a complex baseband stream.
//
// Each accepted sample is multiplied by the conjugate of the previously
// accepted sample. The phase of that product is approximated with the
// first-order arctangent  angle = base - (pi/4) * (x - |y|) / (x + |y|),
// using a bit-serial restoring divider. The angle is then scaled by GAIN.
// All values are signed Q10.
//
// Ports:
//   clock             single clock, rising edge
//   reset             synchronous, active-high
//   Iin, Qin          in-phase / quadrature sample (signed Q10)
//   newDataAvailible  Iin/Qin valid this cycle
//   demodOut          demodulated sample (signed Q10), held between results
//   Done              one-cycle pulse when demodOut has been updated
//   ready             block will take a sample this cycle
module fm_demod #(
    parameter int DATA_WIDTH = 32,
    parameter int GAIN       = 758,
    parameter int QUARTER_PI = 804
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] Iin,
    input  logic signed [DATA_WIDTH-1:0] Qin,
    input  logic                         newDataAvailible,
    output logic signed [DATA_WIDTH-1:0] demodOut,
    output logic                         Done,
    output logic                         ready
);

    localparam int DW = DATA_WIDTH;
    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    localparam logic signed [PW-1:0] GAIN_X   = PW'(GAIN);
    localparam logic signed [PW-1:0] QPI_X    = PW'(QUARTER_PI);
    localparam logic signed [PW-1:0] DQ_BIAS  = PW'(1023);
    localparam logic signed [DW-1:0] BASE_LO  = DW'(QUARTER_PI);
    localparam logic signed [DW-1:0] BASE_HI  = DW'(3 * QUARTER_PI);
    localparam logic [CW-1:0]        LAST_IT  = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        SETUP,
        DIVIDE,
        FINISH
    } state_t;

    state_t state, next_state;
    logic   accept;

    logic signed [DW-1:0] cur_i, cur_q;
    logic signed [DW-1:0] prev_i, prev_q;
    logic signed [DW-1:0] real_r, imag_r;
    logic signed [DW-1:0] base_r;
    logic        [DW-1:0] div_shift;
    logic        [DW-1:0] den_mag_r;
    logic        [DW-1:0] rem;
    logic        [DW-1:0] quo;
    logic                 q_neg;
    logic        [CW-1:0] iter;

    // Q10 rescale: divide by 1024 rounding toward zero, keep the low DW bits.
    // Negative values get a bias of 1023 so the arithmetic shift truncates
    // toward zero instead of toward minus infinity.
    function automatic logic signed [DW-1:0] dq(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] adj;
        adj = v + (v[PW-1] ? DQ_BIAS : '0);
        return DW'(adj >>> 10);
    endfunction

    function automatic logic signed [PW-1:0] sext(input logic signed [DW-1:0] v);
        return {{DW{v[DW-1]}}, v};
    endfunction

    // Sequencing: a sample is taken only in IDLE and never in the cycle the
    // previous result is being announced, so a pulse that lands while busy
    // is simply lost.
    always_comb begin
        next_state = state;
        ready      = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                ready  = !Done;
                accept = !Done && newDataAvailible;
                if (accept) begin
                    next_state = MULT;
                end
            end
            MULT:    next_state = SETUP;
            SETUP:   next_state = DIVIDE;
            DIVIDE: begin
                if (iter == LAST_IT) begin
                    next_state = FINISH;
                end
            end
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Conjugate product cur * conj(prev), full width before rescaling.
    logic signed [PW-1:0] real_sum, imag_sum;

    always_comb begin
        real_sum = sext(cur_i) * sext(prev_i) + sext(cur_q) * sext(prev_q);
        imag_sum = sext(cur_q) * sext(prev_i) - sext(cur_i) * sext(prev_q);
    end

    // Divider operands. The +1 on |imag| keeps the denominator nonzero when
    // both components vanish. The x1024 scale and the sums wrap at DW bits.
    logic signed [DW-1:0] abs_y, num_c, den_c;
    logic        [DW-1:0] num_mag, den_mag;

    always_comb begin
        abs_y = (imag_r[DW-1] ? -imag_r : imag_r) + DW'(1);
        if (!real_r[DW-1]) begin
            num_c = (real_r - abs_y) <<< 10;
            den_c = real_r + abs_y;
        end else begin
            num_c = (real_r + abs_y) <<< 10;
            den_c = abs_y - real_r;
        end
        num_mag = num_c[DW-1] ? -num_c : num_c;
        den_mag = den_c[DW-1] ? -den_c : den_c;
    end

    // One restoring step: bring down the next dividend bit and subtract the
    // divisor if it fits.
    logic [DW:0]   rem_shift;
    logic          q_bit;
    logic [DW-1:0] rem_next;

    always_comb begin
        rem_shift = {rem, div_shift[DW-1]};
        q_bit     = (rem_shift >= {1'b0, den_mag_r});
        rem_next  = q_bit ? DW'(rem_shift - {1'b0, den_mag_r}) : rem_shift[DW-1:0];
    end

    // Angle from the signed quotient, mirrored below the real axis, then
    // scaled by the demodulator gain.
    logic signed [DW-1:0] fin_q, fin_angle, fin_out;

    always_comb begin
        fin_q     = q_neg ? -quo : quo;
        fin_angle = base_r - dq(QPI_X * sext(fin_q));
        if (imag_r[DW-1]) begin
            fin_angle = -fin_angle;
        end
        fin_out   = dq(GAIN_X * sext(fin_angle));
    end

    // Datapath registers, advanced according to the current state.
    always_ff @(posedge clock) begin
        if (reset) begin
            cur_i     <= '0;
            cur_q     <= '0;
            prev_i    <= '0;
            prev_q    <= '0;
            real_r    <= '0;
            imag_r    <= '0;
            base_r    <= '0;
            div_shift <= '0;
            den_mag_r <= '0;
            rem       <= '0;
            quo       <= '0;
            q_neg     <= 1'b0;
            iter      <= '0;
            demodOut  <= '0;
            Done      <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cur_i <= Iin;
                        cur_q <= Qin;
                    end
                end
                MULT: begin
                    real_r <= dq(real_sum);
                    imag_r <= dq(imag_sum);
                    prev_i <= cur_i;
                    prev_q <= cur_q;
                end
                SETUP: begin
                    base_r    <= real_r[DW-1] ? BASE_HI : BASE_LO;
                    div_shift <= num_mag;
                    den_mag_r <= den_mag;
                    q_neg     <= num_c[DW-1] ^ den_c[DW-1];
                    rem       <= '0;
                    quo       <= '0;
                    iter      <= '0;
                end
                DIVIDE: begin
                    rem       <= rem_next;
                    quo       <= {quo[DW-2:0], q_bit};
                    div_shift <= div_shift << 1;
                    iter      <= iter + CW'(1);
                end
                FINISH: begin
                    demodOut <= fin_out;
                    Done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fm_demod.sv
// tb_fm_demod -- self-checking bench for fm_demod.
//
// A reference model tracks which pulses are taken, when each result is due
// and what it must be; a compare process checks Done, ready and demodOut
// against it every cycle. Directed transactions also check hand-computed
// literal results and the accept-to-Done latency.
module tb_fm_demod;

    logic               clock;
    logic               reset;
    logic signed [31:0] Iin;
    logic signed [31:0] Qin;
    logic               newDataAvailible;
    logic signed [31:0] demodOut;
    logic               Done;
    logic               ready;

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference model state
    int m_prev_i  = 0;
    int m_prev_q  = 0;
    int m_timer   = 0;
    bit m_done    = 1'b0;
    int m_held    = 0;
    int m_pending = 0;

    fm_demod #(
        .DATA_WIDTH(32),
        .GAIN      (758),
        .QUARTER_PI(804)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .Iin             (Iin),
        .Qin             (Qin),
        .newDataAvailible(newDataAvailible),
        .demodOut        (demodOut),
        .Done            (Done),
        .ready           (ready)
    );

    // Clock generation, 10 time units per cycle
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Expected output for one sample, straight from the arithmetic rules:
    // conjugate product, first-order arctangent, gain, all in Q10.
    function automatic int expectedDemod(input int ci, input int cq, input int pi, input int pq);
        longint re64, im64, a, b, qm;
        int     re, im, abs_y, num, den, base, q, ang;
        re64  = longint'(ci) * longint'(pi) + longint'(cq) * longint'(pq);
        im64  = longint'(cq) * longint'(pi) - longint'(ci) * longint'(pq);
        re    = int'(re64 / 64'sd1024);
        im    = int'(im64 / 64'sd1024);
        abs_y = ((im < 0) ? -im : im) + 1;
        if (re >= 0) begin
            num  = (re - abs_y) * 1024;
            den  = re + abs_y;
            base = 804;
        end else begin
            num  = (re + abs_y) * 1024;
            den  = abs_y - re;
            base = 3 * 804;
        end
        a  = (num < 0) ? -longint'(num) : longint'(num);
        b  = (den < 0) ? -longint'(den) : longint'(den);
        qm = a / b;
        q  = ((num < 0) != (den < 0)) ? int'(-qm) : int'(qm);
        ang = base - int'((longint'(804) * longint'(q)) / 64'sd1024);
        if (im < 0) ang = -ang;
        return int'((longint'(758) * longint'(ang)) / 64'sd1024);
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks_total++;
        if (actual == expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Model update on every rising edge, using the inputs as the DUT sees them.
    // A pulse is taken only when nothing is in flight and no result is being
    // announced; the result appears 35 edges after the accepting edge.
    initial begin
        bit acc;
        forever begin
            @(posedge clock);
            if (reset) begin
                m_prev_i = 0;
                m_prev_q = 0;
                m_timer  = 0;
                m_done   = 1'b0;
                m_held   = 0;
            end else begin
                acc    = newDataAvailible && (m_timer == 0) && !m_done;
                m_done = 1'b0;
                if (m_timer > 0) begin
                    m_timer--;
                    if (m_timer == 0) begin
                        m_done = 1'b1;
                        m_held = m_pending;
                    end
                end
                if (acc) begin
                    m_pending = expectedDemod(Iin, Qin, m_prev_i, m_prev_q);
                    m_prev_i  = Iin;
                    m_prev_q  = Qin;
                    m_timer   = 35;
                end
            end
        end
    end

    // Cycle-by-cycle comparison on the falling edge
    initial begin
        @(posedge clock);
        forever begin
            @(negedge clock);
            checkOutput("Done", Done, m_done);
            checkOutput("ready", ready, (m_timer == 0) && !m_done);
            checkOutput("demodOut", demodOut, m_held);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Present one sample for a single cycle
    task automatic applyStimulus(input int i, input int q);
        Iin              = i;
        Qin              = q;
        newDataAvailible = 1'b1;
        @(posedge clock);
        #1;
        newDataAvailible = 1'b0;
    endtask

    // Wait a bounded number of edges for Done; check when it arrived and
    // step past the Done cycle.
    task automatic waitDone(input string name, input int remaining);
        int n;
        for (n = 1; n <= 60; n++) begin
            @(posedge clock);
            #1;
            if (Done) break;
        end
        checkOutput({name, " latency"}, n, remaining);
        tick(1);
    endtask

    initial begin
        Iin              = 0;
        Qin              = 0;
        newDataAvailible = 1'b0;
        reset            = 1'b1;
        tick(3);
        reset = 1'b0;
        checkOutput("reset ready", ready, 1);
        checkOutput("reset Done", Done, 0);
        checkOutput("reset demodOut", demodOut, 0);

        // Zero sample after reset
        applyStimulus(0, 0);
        waitDone("zero", 35);
        checkOutput("zero result", demodOut, 1190);

        // No rotation between identical samples
        applyStimulus(1024, 0);
        waitDone("first 1024", 35);
        checkOutput("first 1024 result", demodOut, 1190);
        applyStimulus(1024, 0);
        waitDone("same phase", 35);
        checkOutput("same phase result", demodOut, 1);

        // Quarter turn clockwise
        applyStimulus(0, -1024);
        waitDone("minus quarter", 35);
        checkOutput("minus quarter result", demodOut, -1190);

        // Back to (1024,0), then a half turn
        applyStimulus(1024, 0);
        waitDone("plus quarter", 35);
        checkOutput("plus quarter result", demodOut, 1190);
        applyStimulus(-1024, 0);
        waitDone("half turn", 35);
        checkOutput("half turn result", demodOut, 2379);

        // Pulse during DIVIDE is dropped; prev stays at (1024,0)
        applyStimulus(1024, 0);
        tick(10);
        applyStimulus(555, 777);
        waitDone("drop carrier", 24);
        checkOutput("drop carrier result", demodOut, 2379);
        tick(40);
        applyStimulus(1024, 0);
        waitDone("after drop", 35);
        checkOutput("after drop result", demodOut, 1);

        // Reset partway through a computation
        applyStimulus(300, -200);
        tick(19);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(45);
        checkOutput("abort demodOut", demodOut, 0);
        checkOutput("abort ready", ready, 1);
        applyStimulus(0, 0);
        waitDone("after abort", 35);
        checkOutput("after abort result", demodOut, 1190);

        // Reset wins over a simultaneous sample: next result uses prev=(0,0)
        Iin              = 1024;
        Qin              = 0;
        newDataAvailible = 1'b1;
        reset            = 1'b1;
        tick(1);
        reset            = 1'b0;
        newDataAvailible = 1'b0;
        tick(40);
        applyStimulus(1024, 0);
        waitDone("reset priority", 35);
        checkOutput("reset priority result", demodOut, 1190);

        // Larger operands, including wrap of the scaled numerator
        applyStimulus(5000, -3000);
        waitDone("vec a", 35);
        applyStimulus(-7000, 2000);
        waitDone("vec b", 35);
        applyStimulus(123456, -654321);
        waitDone("vec c", 35);
        applyStimulus(-40000, -90000);
        waitDone("vec d", 35);
        tick(3);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded %0d time units", 200000);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
